// File: rtl/icache_pkg.sv
// Shared definitions for the icache tag store: entry layout, FSM encoding
// and the width derivations used by the interface and the top level.
package icache_pkg;

    localparam int TAG_W_DEF = 19;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    function automatic int calc_idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int calc_way_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    // The valid flag sits directly above the stored tag bits.
    function automatic int valid_pos(input int tag_w);
        return tag_w;
    endfunction

endpackage

// File: rtl/icache_tag_array_if.sv
// Lookup, fill and flush signals between the fetch/refill logic and the
// icache tag store.
interface icache_tag_array_if #(
    parameter int WAYS  = 2,
    parameter int SETS  = 256,
    parameter int TAG_W = icache_pkg::TAG_W_DEF
);
    import icache_pkg::*;

    localparam int IDX_W = calc_idx_w(SETS);
    localparam int WAY_W = calc_way_w(WAYS);

    logic             lookup_valid_i;
    logic             lookup_ready_o;
    logic [IDX_W-1:0] lookup_idx_i;
    logic [TAG_W-1:0] lookup_tag_i;
    logic             resp_valid_o;
    logic             hit_o;
    logic [WAY_W-1:0] hit_way_o;
    logic [WAY_W-1:0] victim_way_o;
    logic             fill_valid_i;
    logic [IDX_W-1:0] fill_idx_i;
    logic [WAY_W-1:0] fill_way_i;
    logic [TAG_W-1:0] fill_tag_i;
    logic             flush_i;
    logic             busy_o;

    modport slave (
        input  lookup_valid_i, lookup_idx_i, lookup_tag_i,
        input  fill_valid_i, fill_idx_i, fill_way_i, fill_tag_i, flush_i,
        output lookup_ready_o, resp_valid_o, hit_o, hit_way_o, victim_way_o, busy_o
    );

    modport master (
        output lookup_valid_i, lookup_idx_i, lookup_tag_i,
        output fill_valid_i, fill_idx_i, fill_way_i, fill_tag_i, flush_i,
        input  lookup_ready_o, resp_valid_o, hit_o, hit_way_o, victim_way_o, busy_o
    );

endinterface

// File: rtl/icache_tag_way_ram.sv
// Single-port read-first RAM holding one way of tag entries; no reset, the
// invalidate sweep is responsible for bringing contents to a known state.
module icache_tag_way_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 20
) (
    input  logic                     clk_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     wr_i,
    output logic [WIDTH-1:0]         data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_i) begin
            mem_q[addr_i] <= data_i;
        end
        data_o <= mem_q[addr_i];
    end

endmodule

// File: rtl/icache_tag_array.sv
// Set-associative icache tag store with one-cycle registered lookup,
// per-set round-robin victim pointers and a hardware invalidate sweep.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | lookups and fills accepted
//   ST_SWEEP | writing invalid entries to set cnt_q, one set per cycle
module icache_tag_array
    import icache_pkg::*;
#(
    parameter int WAYS  = 2,
    parameter int SETS  = 256,
    parameter int TAG_W = TAG_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    icache_tag_array_if.slave bus
);

    localparam int IDX_W = calc_idx_w(SETS);
    localparam int WAY_W = calc_way_w(WAYS);
    localparam int ENT_W = TAG_W + 1;
    localparam int VLD   = valid_pos(TAG_W);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             busy;
    logic             lookup_acc;

    logic [IDX_W-1:0] ram_addr;
    logic [ENT_W-1:0] ram_wdata;
    logic [WAYS-1:0]  ram_wr;
    logic [ENT_W-1:0] ram_rd [WAYS];

    logic             resp_valid_q;
    logic [TAG_W-1:0] tag_q;
    logic [WAY_W-1:0] rr_cur;
    logic [WAY_W-1:0] rr_snap_q;
    logic             hit_q;
    logic [WAY_W-1:0] hit_way_q;
    logic [WAY_W-1:0] victim_q;

    logic             hit_c;
    logic [WAY_W-1:0] hit_way_c;
    logic             inv_c;
    logic [WAY_W-1:0] inv_way_c;
    logic [WAY_W-1:0] victim_c;

    assign busy       = (state_q == ST_SWEEP);
    assign lookup_acc = bus.lookup_valid_i && !busy && !bus.fill_valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.flush_i) begin
                    state_d = ST_SWEEP;
                    cnt_d   = '0;
                end
            end
            ST_SWEEP: begin
                if (bus.flush_i) begin
                    cnt_d = '0;
                end else if (cnt_q == IDX_W'(SETS - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_SWEEP;
                cnt_d   = '0;
            end
        endcase
    end

    // Sweep owns the RAM port outright; a fill steals it from a lookup.
    always_comb begin
        ram_addr  = bus.lookup_idx_i;
        ram_wdata = {1'b1, bus.fill_tag_i};
        if (busy) begin
            ram_addr  = cnt_q;
            ram_wdata = '0;
        end else if (bus.fill_valid_i) begin
            ram_addr = bus.fill_idx_i;
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign ram_wr[w] = busy || (bus.fill_valid_i && (bus.fill_way_i == WAY_W'(w)));

        icache_tag_way_ram #(
            .DEPTH (SETS),
            .WIDTH (ENT_W)
        ) u_ram (
            .clk_i  (clk_i),
            .addr_i (ram_addr),
            .data_i (ram_wdata),
            .wr_i   (ram_wr[w]),
            .data_o (ram_rd[w])
        );
    end

    if (WAYS > 1) begin : g_rr
        logic [WAY_W-1:0] rr_q [SETS];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int s = 0; s < SETS; s++) begin
                    rr_q[s] <= '0;
                end
            end else if (busy) begin
                rr_q[cnt_q] <= '0;
            end else if (bus.fill_valid_i) begin
                rr_q[bus.fill_idx_i] <= rr_q[bus.fill_idx_i] + 1'b1;
            end
        end

        assign rr_cur = rr_q[bus.lookup_idx_i];
    end else begin : g_no_rr
        assign rr_cur = '0;
    end

    // Descending scan so the lowest-numbered candidate wins.
    always_comb begin
        hit_c     = 1'b0;
        hit_way_c = '0;
        inv_c     = 1'b0;
        inv_way_c = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (ram_rd[w][VLD] && (ram_rd[w][TAG_W-1:0] == tag_q)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_W'(w);
            end
            if (!ram_rd[w][VLD]) begin
                inv_c     = 1'b1;
                inv_way_c = WAY_W'(w);
            end
        end
        victim_c = inv_c ? inv_way_c : rr_snap_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            tag_q        <= '0;
            rr_snap_q    <= '0;
            hit_q        <= 1'b0;
            hit_way_q    <= '0;
            victim_q     <= '0;
        end else begin
            resp_valid_q <= lookup_acc;
            if (lookup_acc) begin
                tag_q     <= bus.lookup_tag_i;
                rr_snap_q <= rr_cur;
            end
            if (resp_valid_q) begin
                hit_q     <= hit_c;
                hit_way_q <= hit_way_c;
                victim_q  <= victim_c;
            end
        end
    end

    // The RAM output moves with every later access, so results are frozen
    // in hold registers after the response cycle.
    assign bus.resp_valid_o   = resp_valid_q;
    assign bus.hit_o          = resp_valid_q ? hit_c     : hit_q;
    assign bus.hit_way_o      = resp_valid_q ? hit_way_c : hit_way_q;
    assign bus.victim_way_o   = resp_valid_q ? victim_c  : victim_q;
    assign bus.busy_o         = busy;
    assign bus.lookup_ready_o = !busy && !bus.fill_valid_i;

endmodule

// File: doc/icache_tag_array.md
# icache_tag_array

Parametrised, set-associative instruction-cache tag store with per-line valid bits, registered hit/way compare, per-set round-robin victim selection and a hardware invalidate sweep. It sits between the icache fetch pipeline and the data RAMs: the fetch stage presents an index/tag and gets hit, hit way and victim way one cycle later. The refill engine writes new tags through the fill port, and a flush (fence.i) clears every line without software loops.

## Interface
Parameters:
- WAYS, 2: associativity. Power of two, 1..8.
- SETS, 256: number of sets. Power of two, 16..1024.
- TAG_W, 19: stored tag width, excluding the valid bit.
- Derived: IDX_W = log2(SETS), WAY_W = max(1, log2(WAYS)).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- lookup_valid_i  in  1  lookup request this cycle.
- lookup_ready_o  out  1  lookup accepted; equals !busy_o && !fill_valid_i.
- lookup_idx_i  in  IDX_W  set index.
- lookup_tag_i  in  TAG_W  tag to compare.
- resp_valid_o  out  1  lookup result valid; accepted lookup plus 1 cycle.
- hit_o  out  1  a valid way matched.
- hit_way_o  out  WAY_W  matching way (binary).
- victim_way_o  out  WAY_W  way to refill on a miss.
- fill_valid_i  in  1  write tag; takes priority over lookup.
- fill_idx_i  in  IDX_W  fill set.
- fill_way_i  in  WAY_W  fill way.
- fill_tag_i  in  TAG_W  tag written with valid = 1.
- flush_i  in  1  single-cycle pulse; invalidate all lines.
- busy_o  out  1  invalidate sweep in progress.

## Operation
- Storage: each way holds a SETS x (TAG_W+1) single-port, read-first RAM; bit TAG_W is the valid bit. The RAMs have no reset.
- Address mux priority:
  - sweep counter, when busy_o;
  - fill_idx_i, when fill_valid_i;
  - lookup_idx_i otherwise.
- Fill: writes {1, fill_tag_i} into way fill_way_i only. The other ways are not written.
- Fill while busy_o is dropped; the refill engine must not issue it.
- Lookup: the index is read from all ways in parallel. On the next cycle:
  - hit_o = OR over ways of (valid && tag == lookup_tag_i, registered);
  - hit_way_o = lowest matching way;
  - victim_way_o = lowest invalid way in the set if any, else the set's round-robin pointer.
- Round-robin pointers: SETS x WAY_W flops, cleared by reset and by the sweep. The pointer for fill_idx_i advances by 1 (mod WAYS) on every accepted fill to that set.
- FSM states IDLE and SWEEP:
  - Reset enters SWEEP with the counter at 0.
  - Each SWEEP cycle writes {0, 0} to index counter in all ways and clears that set's pointer.
  - At counter == SETS-1, go to IDLE.
  - flush_i in IDLE → SWEEP, counter = 0.
  - flush_i during SWEEP restarts the counter at 0.
- WAYS == 1: hit_way_o and victim_way_o are constant 0 and no pointers exist.

## Timing
- Reset values: busy_o = 1, resp_valid_o = 0, hit_o = 0, hit_way_o = 0, victim_way_o = 0, lookup_ready_o = 0.
- A sweep takes exactly SETS cycles. busy_o falls after the last write; the first lookup can be accepted the cycle busy_o is 0.
- Lookup latency is 1 cycle. Results hold until the next accepted lookup; resp_valid_o is a 1-cycle pulse.
- Fill and lookup in the same cycle: the fill wins and the lookup is not accepted (lookup_ready_o = 0). The requester re-presents the lookup.
- Fill followed next cycle by a lookup of the same index/tag gives hit_o = 1 with hit_way_o = fill_way_i.
- Reset asserted mid-sweep or mid-lookup: outputs return to reset values immediately and the sweep restarts from 0 after release.

## Structure
- Shared package icache_pkg holds:
  - the entry layout (valid bit position, TAG_W default);
  - the FSM state encoding (IDLE, SWEEP);
  - the IDX_W/WAY_W derivation functions.
- Sub-module icache_tag_way_ram: one single-port read-first RAM, parameters DEPTH and WIDTH, ports clk_i/addr_i/data_i/wr_i/data_o. It is instantiated WAYS times via generate.

## Test plan
- Reset release: busy_o = 1 for 256 cycles (SETS = 256), then 0. A lookup of idx 0x00, tag 0 gives hit_o = 0 and victim_way_o = 0.
- Fill idx 0x12 way 1 tag 0x1ABCD, then lookup idx 0x12 tag 0x1ABCD: hit_o = 1, hit_way_o = 1. Lookup of tag 0x1ABCE gives hit_o = 0 and victim_way_o = 0 (way 0 invalid).
- Fill both ways of idx 0x40, then 3 more fills to idx 0x40: the pointer sequence, and therefore victim_way_o on successive misses, follows 0, 1, 0, 1.
- Fill and lookup asserted in the same cycle: lookup_ready_o = 0, no resp_valid_o pulse, and the fill is visible to the retried lookup.
- Fill 4 lines, pulse flush_i, pulse flush_i again 100 cycles later: busy_o stays high 100 + 256 cycles total, and all 4 lines miss afterwards.
- Assert rst_i at sweep count 50: outputs are at reset values immediately, the sweep restarts at 0, and busy_o lasts a full 256 cycles after release.
